sparc_mpu: RTL and testbench
============================

Name: sparc_mpu

Overview:
- Microprogrammed, multi-cycle SPARC-V8 integer subset processor with a 512-byte internal byte-addressed RAM.
- A hardwired control unit sequences a datapath: PC, MAR, MDR, IR, 32x32 register file, ALU, shifter and flag register.
- Exposes the current microstate, IR and MAR for observation.
- Top-level unit under system simulation.

Parameters:
- MEM_BYTES, 512: RAM size in bytes; addresses wrap modulo MEM_BYTES (9-bit MAR).
- RESET_PC, 0: PC value loaded on reset.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Clr  in  1  reset, synchronous, active-high.
- State  out  7  current microstate number.
- wIROut  out  32  instruction register.
- wMAROut  out  32  MAR, zero-extended from 9 bits.

Behaviour:
- Reset (Clr=1 at edge) forces:
  - State=0, PC=RESET_PC, IR=0, MAR=0, MDR=0, FR=0.
  - Registers and RAM are not cleared.
- Flag register FR is 4 bits: [3]=C, [2]=N, [1]=V, [0]=Z.
- Memory is big-endian with a MOC handshake:
  - A read or write asserts MOV; MOC is returned one cycle later.
  - The waiting state holds until MOC=1.
  - Word accesses force MAR[1:0]=00.
- States and transitions:
  - 0 RESET -> 1.
  - 1 FETCH: MAR<=PC -> 2.
  - 2 FETCH_RD: read word; wait MOC; MDR<=word -> 3.
  - 3 IR_LOAD: IR<=MDR, PC<=PC+4 -> 4.
  - 4 DECODE: dispatch on op/op2/op3. Any unlisted encoding -> 63.
  - 10 ALU: rd<=rs1 OP op2 (op2 = sign-extended simm13 if i=1, else rs2) -> 1.
    - op3 000000 add, 000001 and, 000010 or, 000011 xor, 000100 sub.
    - Same with bit4 set (01xxxx): cc variants, which update FR.
    - 100101 sll, 100110 srl, 100111 sra: shift count op2[4:0], FR unchanged.
  - 11 SETHI (op=00, op2=100): rd<={imm22,10'b0} -> 1.
  - 12 BICC (op=00, op2=010): if cond(FR) true, PC<=PC-4+(sext(disp22)<<2) -> 1.
    - All 16 SPARC cond codes are supported.
    - Annul bit ignored; no delay slot.
  - 13 CALL (op=01): r15<=PC-4; PC<=PC-4+(disp30<<2) -> 1.
  - 14 JMPL (op=10, op3=111000): rd<=PC-4; PC<=rs1+op2 -> 1.
  - 20 LDST_ADDR (op=11): MAR<=rs1+op2 -> 21 for loads, 23 for stores.
    - op3 000000 ld, 000001 ldub, 000100 st, 000101 stb.
  - 21 LD_RD: wait MOC -> 22.
  - 22 LD_WB: rd<=MDR (word, or zero-extended byte) -> 1.
  - 23 ST_DATA: MDR<=rd (word or low byte) -> 24.
  - 24 ST_WR: write; wait MOC -> 1.
  - 63 HALT: stays until Clr.
- Register file: r0 reads 0; writes to r0 are discarded. No register windows.
- Flag rules:
  - N = result[31]; Z = (result==0).
  - add: C = carry out, V = signed overflow.
  - sub: C = borrow, V = signed overflow.
  - logical ops: C=V=0.
- All arithmetic is modulo 2^32.
- Reset asserted mid-access aborts the access. A store completes only if MOC was reached before reset.

Optional Feature:
- SPARC_MPU_PRELOAD_EN defined: at time 0 the RAM is initialised with $readmemb from file "input.txt", one byte per line starting at address 0.
- Not defined: RAM contents are undefined until written. The bench preloads memory hierarchically.

Decomposition:
- Package sparc_mpu_pkg holds:
  - state number constants (0-24, 63);
  - op/op3 opcode constants;
  - cond code constants;
  - FR bit indices.
- One sub-module, sparc_mpu_alu: combinational ALU plus shifter producing result and CNVZ.
- RAM, register file and sequencer are inlined.

Test Plan:
- Reset: Clr=1 for one edge -> State=0, then 1,2,...; wMAROut=0 on the first fetch; FR=0000.
- ALU/flags: after sethi r1=0x7FFFFC00, or r1,0x3FF; addcc r2,r1,1 -> r2=0x80000000, FR=0110 (N,V). subcc r3,r0,r0 -> r3=0, FR=0001.
- Load/store: st r2 at 0x40 then ld r4 from 0x40 -> r4=r2; ldub from 0x40 -> 0x00000080; wMAROut=0x40 during the access.
- Branch: be taken with Z=1 jumps by disp22=2 (PC-4+8); bne with Z=1 falls through; ba always taken; bn never taken.
- Call/jmpl: call disp30=4 from PC 0x10 -> r15=0x10, PC=0x20; jmpl r15+8,r0 returns to 0x18.
- Illegal: opcode op=00, op2=111 -> State=63 holds; Clr returns State to 0.

Source files
------------

// File: rtl/sparc_mpu_pkg.sv
// sparc_mpu_pkg: shared constants for the sparc_mpu processor.
// Holds the microstate numbering, SPARC-V8 opcode fields used by the
// decoder, branch condition codes, flag register bit positions and two
// small decode helpers.
package sparc_mpu_pkg;

  // Microstate numbers; these values are visible on the State port.
  typedef enum logic [6:0] {
    ST_RESET     = 7'd0,
    ST_FETCH     = 7'd1,
    ST_FETCH_RD  = 7'd2,
    ST_IR_LOAD   = 7'd3,
    ST_DECODE    = 7'd4,
    ST_ALU       = 7'd10,
    ST_SETHI     = 7'd11,
    ST_BICC      = 7'd12,
    ST_CALL      = 7'd13,
    ST_JMPL      = 7'd14,
    ST_LDST_ADDR = 7'd20,
    ST_LD_RD     = 7'd21,
    ST_LD_WB     = 7'd22,
    ST_ST_DATA   = 7'd23,
    ST_ST_WR     = 7'd24,
    ST_HALT      = 7'd63
  } state_t;

  // Instruction format selector (ir[31:30]).
  localparam logic [1:0] OP_FMT2  = 2'b00;
  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_MEM   = 2'b11;

  // Format-2 sub-opcodes (ir[24:22]).
  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  // Arithmetic op3 codes (op = 10).
  localparam logic [5:0] OP3_ADD   = 6'b000000;
  localparam logic [5:0] OP3_AND   = 6'b000001;
  localparam logic [5:0] OP3_OR    = 6'b000010;
  localparam logic [5:0] OP3_XOR   = 6'b000011;
  localparam logic [5:0] OP3_SUB   = 6'b000100;
  localparam logic [5:0] OP3_ADDCC = 6'b010000;
  localparam logic [5:0] OP3_ANDCC = 6'b010001;
  localparam logic [5:0] OP3_ORCC  = 6'b010010;
  localparam logic [5:0] OP3_XORCC = 6'b010011;
  localparam logic [5:0] OP3_SUBCC = 6'b010100;
  localparam logic [5:0] OP3_SLL   = 6'b100101;
  localparam logic [5:0] OP3_SRL   = 6'b100110;
  localparam logic [5:0] OP3_SRA   = 6'b100111;
  localparam logic [5:0] OP3_JMPL  = 6'b111000;

  // Memory op3 codes (op = 11). Bit 2 marks a store, bit 0 a byte access.
  localparam logic [5:0] OP3_LD    = 6'b000000;
  localparam logic [5:0] OP3_LDUB  = 6'b000001;
  localparam logic [5:0] OP3_ST    = 6'b000100;
  localparam logic [5:0] OP3_STB   = 6'b000101;

  // Branch condition codes (ir[28:25]).
  localparam logic [3:0] COND_N   = 4'd0;
  localparam logic [3:0] COND_E   = 4'd1;
  localparam logic [3:0] COND_LE  = 4'd2;
  localparam logic [3:0] COND_L   = 4'd3;
  localparam logic [3:0] COND_LEU = 4'd4;
  localparam logic [3:0] COND_CS  = 4'd5;
  localparam logic [3:0] COND_NEG = 4'd6;
  localparam logic [3:0] COND_VS  = 4'd7;
  localparam logic [3:0] COND_A   = 4'd8;
  localparam logic [3:0] COND_NE  = 4'd9;
  localparam logic [3:0] COND_G   = 4'd10;
  localparam logic [3:0] COND_GE  = 4'd11;
  localparam logic [3:0] COND_GU  = 4'd12;
  localparam logic [3:0] COND_CC  = 4'd13;
  localparam logic [3:0] COND_POS = 4'd14;
  localparam logic [3:0] COND_VC  = 4'd15;

  // Flag register bit positions.
  localparam int FR_C = 3;
  localparam int FR_N = 2;
  localparam int FR_V = 1;
  localparam int FR_Z = 0;

  // Evaluate an integer branch condition against the flags.
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] fr);
    logic c, n, v, z, res;
    c = fr[FR_C];
    n = fr[FR_N];
    v = fr[FR_V];
    z = fr[FR_Z];
    case (cond)
      COND_N:   res = 1'b0;
      COND_E:   res = z;
      COND_LE:  res = z | (n ^ v);
      COND_L:   res = n ^ v;
      COND_LEU: res = c | z;
      COND_CS:  res = c;
      COND_NEG: res = n;
      COND_VS:  res = v;
      COND_A:   res = 1'b1;
      COND_NE:  res = ~z;
      COND_G:   res = ~(z | (n ^ v));
      COND_GE:  res = ~(n ^ v);
      COND_GU:  res = ~(c | z);
      COND_CC:  res = ~c;
      COND_POS: res = ~n;
      COND_VC:  res = ~v;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

  // True for op3 values executed by the ALU state.
  function automatic logic is_alu_op3(input logic [5:0] op3);
    logic res;
    case (op3)
      OP3_ADD, OP3_AND, OP3_OR, OP3_XOR, OP3_SUB,
      OP3_ADDCC, OP3_ANDCC, OP3_ORCC, OP3_XORCC, OP3_SUBCC,
      OP3_SLL, OP3_SRL, OP3_SRA: res = 1'b1;
      default:                   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sparc_mpu_alu.sv
// sparc_mpu_alu: combinational ALU and barrel shifter.
// Produces the 32-bit result and candidate flags {C,N,V,Z}; the caller
// decides whether the flags are committed (cc variants only).
module sparc_mpu_alu
  import sparc_mpu_pkg::*;
(
  input  logic [5:0]  op3,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [31:0] result,
  output logic [3:0]  cnvz
);

  logic [32:0] sum;
  logic [32:0] diff;
  logic        carry;
  logic        ovf;

  assign sum  = {1'b0, opa} + {1'b0, opb};
  // Bit 32 of the extended difference is set exactly when opa < opb (borrow).
  assign diff = {1'b0, opa} - {1'b0, opb};

  // Select the operation result and the arithmetic carry/overflow.
  always_comb begin
    result = 32'd0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op3)
      OP3_ADD, OP3_ADDCC: begin
        result = sum[31:0];
        carry  = sum[32];
        ovf    = (opa[31] == opb[31]) && (sum[31] != opa[31]);
      end
      OP3_SUB, OP3_SUBCC: begin
        result = diff[31:0];
        carry  = diff[32];
        ovf    = (opa[31] != opb[31]) && (diff[31] != opa[31]);
      end
      OP3_AND, OP3_ANDCC: result = opa & opb;
      OP3_OR,  OP3_ORCC:  result = opa | opb;
      OP3_XOR, OP3_XORCC: result = opa ^ opb;
      OP3_SLL:            result = opa << opb[4:0];
      OP3_SRL:            result = opa >> opb[4:0];
      OP3_SRA:            result = $signed(opa) >>> opb[4:0];
      default:            result = 32'd0;
    endcase
  end

  assign cnvz = {carry, result[31], ovf, (result == 32'd0)};

endmodule

// File: rtl/sparc_mpu.sv
// sparc_mpu: multi-cycle SPARC-V8 integer subset processor.
// Hardwired sequencer over PC/MAR/MDR/IR, a 32x32 register file, the ALU
// sub-module and a byte-addressed big-endian RAM with a one-cycle MOV/MOC
// handshake. RAM contents are undefined until written.
module sparc_mpu
  import sparc_mpu_pkg::*;
#(
  parameter int          MEM_BYTES = 512,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clr,
  output logic [6:0]  State,
  output logic [31:0] wIROut,
  output logic [31:0] wMAROut
);

  localparam int AW = $clog2(MEM_BYTES);

  state_t          state_reg;
  state_t          decode_state;
  logic [31:0]     pc_reg;
  logic [31:0]     ir_reg;
  logic [31:0]     mdr_reg;
  logic [AW-1:0]   mar_reg;
  logic [3:0]      fr_reg;
  logic            moc_reg;

  logic [7:0]      mem [0:MEM_BYTES-1];
  logic [31:0]     regs [0:31];

  // Instruction fields
  logic [1:0]  op;
  logic [4:0]  rd;
  logic [2:0]  op2;
  logic [5:0]  op3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        imm_sel;
  logic [12:0] simm13;
  logic [21:0] imm22;
  logic [3:0]  cond;
  logic [29:0] disp30;

  assign op      = ir_reg[31:30];
  assign rd      = ir_reg[29:25];
  assign cond    = ir_reg[28:25];
  assign op2     = ir_reg[24:22];
  assign op3     = ir_reg[24:19];
  assign rs1     = ir_reg[18:14];
  assign imm_sel = ir_reg[13];
  assign simm13  = ir_reg[12:0];
  assign rs2     = ir_reg[4:0];
  assign imm22   = ir_reg[21:0];
  assign disp30  = ir_reg[29:0];

  // Operand read; r0 is hardwired to zero regardless of array contents.
  logic [31:0] rs1_val, rs2_val, rd_val, op2_val, ea;
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign rd_val  = (rd  == 5'd0) ? 32'd0 : regs[rd];
  assign op2_val = imm_sel ? {{19{simm13[12]}}, simm13} : rs2_val;
  // Shared by JMPL target and load/store effective address.
  assign ea      = rs1_val + op2_val;

  logic [31:0] alu_result;
  logic [3:0]  alu_cnvz;

  sparc_mpu_alu u_alu (
    .op3    (op3),
    .opa    (rs1_val),
    .opb    (op2_val),
    .result (alu_result),
    .cnvz   (alu_cnvz)
  );

  // Memory access helpers
  logic        is_store;
  logic        is_byte;
  logic        access;
  logic        mem_we;
  logic [31:0] mem_word;
  logic [31:0] load_data;

  assign is_store = op3[2];
  assign is_byte  = op3[0];
  assign access   = (state_reg == ST_FETCH_RD) || (state_reg == ST_LD_RD) ||
                    (state_reg == ST_ST_WR);
  // A store lands only on its MOC cycle and never while reset is applied.
  assign mem_we   = (state_reg == ST_ST_WR) && moc_reg && !Clr;
  assign mem_word = {mem[{mar_reg[AW-1:2], 2'b00}], mem[{mar_reg[AW-1:2], 2'b01}],
                     mem[{mar_reg[AW-1:2], 2'b10}], mem[{mar_reg[AW-1:2], 2'b11}]};
  assign load_data = ((state_reg == ST_LD_RD) && is_byte) ? {24'd0, mem[mar_reg]} : mem_word;

  // RAM write port: big-endian word or single byte.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      if (is_byte) begin
        mem[mar_reg] <= mdr_reg[7:0];
      end else begin
        mem[{mar_reg[AW-1:2], 2'b00}] <= mdr_reg[31:24];
        mem[{mar_reg[AW-1:2], 2'b01}] <= mdr_reg[23:16];
        mem[{mar_reg[AW-1:2], 2'b10}] <= mdr_reg[15:8];
        mem[{mar_reg[AW-1:2], 2'b11}] <= mdr_reg[7:0];
      end
    end
  end

  // Register-file write request per microstate.
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Select register write source for the current microstate.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = alu_result;
    case (state_reg)
      ST_ALU:   rf_we = 1'b1;
      ST_SETHI: begin
        rf_we    = 1'b1;
        rf_wdata = {imm22, 10'd0};
      end
      ST_CALL: begin
        rf_we    = 1'b1;
        rf_waddr = 5'd15;
        rf_wdata = pc_reg - 32'd4;
      end
      ST_JMPL: begin
        rf_we    = 1'b1;
        rf_wdata = pc_reg - 32'd4;
      end
      ST_LD_WB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_reg;
      end
      default: rf_we = 1'b0;
    endcase
  end

  // Register file write; r0 writes are dropped, contents survive reset.
  always_ff @(posedge Clk) begin
    if (rf_we && !Clr && (rf_waddr != 5'd0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Instruction dispatch; anything not recognised halts the machine.
  always_comb begin
    decode_state = ST_HALT;
    case (op)
      OP_FMT2: begin
        if (op2 == OP2_SETHI)     decode_state = ST_SETHI;
        else if (op2 == OP2_BICC) decode_state = ST_BICC;
      end
      OP_CALL: decode_state = ST_CALL;
      OP_ARITH: begin
        if (is_alu_op3(op3))       decode_state = ST_ALU;
        else if (op3 == OP3_JMPL) decode_state = ST_JMPL;
      end
      OP_MEM: begin
        if ((op3 == OP3_LD) || (op3 == OP3_LDUB) || (op3 == OP3_ST) || (op3 == OP3_STB))
          decode_state = ST_LDST_ADDR;
      end
      default: decode_state = ST_HALT;
    endcase
  end

  // Sequencer: microstate, datapath registers and MOC handshake.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_reg <= ST_RESET;
      pc_reg    <= RESET_PC;
      ir_reg    <= 32'd0;
      mar_reg   <= '0;
      mdr_reg   <= 32'd0;
      fr_reg    <= 4'd0;
      moc_reg   <= 1'b0;
    end else begin
      // MOC answers one cycle after an access state starts asserting MOV.
      moc_reg <= access && !moc_reg;
      case (state_reg)
        ST_RESET: state_reg <= ST_FETCH;
        ST_FETCH: begin
          mar_reg   <= {pc_reg[AW-1:2], 2'b00};
          state_reg <= ST_FETCH_RD;
        end
        ST_FETCH_RD: begin
          if (moc_reg) begin
            mdr_reg   <= load_data;
            state_reg <= ST_IR_LOAD;
          end
        end
        ST_IR_LOAD: begin
          ir_reg    <= mdr_reg;
          pc_reg    <= pc_reg + 32'd4;
          state_reg <= ST_DECODE;
        end
        ST_DECODE: state_reg <= decode_state;
        ST_ALU: begin
          if ((op == OP_ARITH) && op3[4] && !op3[5]) fr_reg <= alu_cnvz;
          state_reg <= ST_FETCH;
        end
        ST_SETHI: state_reg <= ST_FETCH;
        ST_BICC: begin
          if (cond_true(cond, fr_reg))
            pc_reg <= pc_reg - 32'd4 + {{8{imm22[21]}}, imm22, 2'b00};
          state_reg <= ST_FETCH;
        end
        ST_CALL: begin
          pc_reg    <= pc_reg - 32'd4 + {disp30, 2'b00};
          state_reg <= ST_FETCH;
        end
        ST_JMPL: begin
          pc_reg    <= ea;
          state_reg <= ST_FETCH;
        end
        ST_LDST_ADDR: begin
          mar_reg   <= is_byte ? ea[AW-1:0] : {ea[AW-1:2], 2'b00};
          state_reg <= is_store ? ST_ST_DATA : ST_LD_RD;
        end
        ST_LD_RD: begin
          if (moc_reg) begin
            mdr_reg   <= load_data;
            state_reg <= ST_LD_WB;
          end
        end
        ST_LD_WB: state_reg <= ST_FETCH;
        ST_ST_DATA: begin
          mdr_reg   <= is_byte ? {24'd0, rd_val[7:0]} : rd_val;
          state_reg <= ST_ST_WR;
        end
        ST_ST_WR: begin
          if (moc_reg) state_reg <= ST_FETCH;
        end
        ST_HALT: state_reg <= ST_HALT;
        default: state_reg <= ST_HALT;
      endcase
    end
  end

  assign State   = state_reg;
  assign wIROut  = ir_reg;
  assign wMAROut = {{(32-AW){1'b0}}, mar_reg};

endmodule

// File: tb/tb_sparc_mpu.sv
// tb_sparc_mpu: directed program run on sparc_mpu with immediate-assertion
// checks after each instruction (registers, PC, flags, memory, MAR).
module tb_sparc_mpu;

  logic        Clk;
  logic        Clr;
  logic [6:0]  State;
  logic [31:0] wIROut;
  logic [31:0] wMAROut;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] access_mar;

  localparam logic [31:0] ILLEGAL = 32'h01C0_0000;

  sparc_mpu dut (
    .Clk     (Clk),
    .Clr     (Clr),
    .State   (State),
    .wIROut  (wIROut),
    .wMAROut (wMAROut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [8:0] addr, input logic [31:0] w);
    dut.mem[addr]         <= w[31:24];
    dut.mem[addr + 9'd1]  <= w[23:16];
    dut.mem[addr + 9'd2]  <= w[15:8];
    dut.mem[addr + 9'd3]  <= w[7:0];
  endtask

  // Run until the current instruction completes (back in FETCH after DECODE).
  task automatic step(input string tag, input logic [31:0] exp_pc);
    bit seen_dec = 1'b0;
    bit done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge Clk);
      #1;
      if (State == 7'd21 || State == 7'd24) access_mar = wMAROut;
      if (State == 7'd4) seen_dec = 1'b1;
      else if (State == 7'd1 && seen_dec) done = 1'b1;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_pc"}, dut.pc_reg, exp_pc);
    $display("step %-6s ir=%h pc=%h fr=%b state=%0d", tag, wIROut, dut.pc_reg, dut.fr_reg, State);
  endtask

  initial begin
    Clr = 1'b1;
    access_mar = 32'd0;
    for (int a = 0; a < 512; a += 4) put_word(9'(a), ILLEGAL);
    put_word(9'h000, 32'h031FFFFF); // sethi 0x1FFFFF, r1
    put_word(9'h004, 32'h821063FF); // or r1, 0x3FF, r1
    put_word(9'h008, 32'h84806001); // addcc r1, 1, r2
    put_word(9'h00C, 32'h86A00000); // subcc r0, r0, r3
    put_word(9'h010, 32'h40000004); // call +4 words
    put_word(9'h018, 32'h00800002); // bn +2
    put_word(9'h01C, 32'h10800005); // ba +5 -> 0x30
    put_word(9'h020, 32'h81C3E008); // jmpl r15+8, r0
    put_word(9'h030, 32'h02800002); // be +2 -> 0x38
    put_word(9'h038, 32'h12800002); // bne +2 (not taken)
    put_word(9'h03C, 32'h10800004); // ba +4 -> 0x4C
    put_word(9'h04C, 32'hC4202040); // st r2, [0x40]
    put_word(9'h050, 32'hC8002040); // ld [0x40], r4
    put_word(9'h054, 32'hCA082040); // ldub [0x40], r5
    put_word(9'h058, 32'h8D38A004); // sra r2, 4, r6
    put_word(9'h05C, 32'h8F30A004); // srl r2, 4, r7

    // Reset
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("rst_state", 32'(State), 32'd0);
    check("rst_ir", wIROut, 32'd0);
    check("rst_mar", wMAROut, 32'd0);
    check("rst_pc", dut.pc_reg, 32'd0);
    check("rst_mdr", dut.mdr_reg, 32'd0);
    check("rst_fr", 32'(dut.fr_reg), 32'd0);
    Clr = 1'b0;
    @(posedge Clk);
    #1;
    check("st_fetch", 32'(State), 32'd1);
    @(posedge Clk);
    #1;
    check("st_fetch_rd", 32'(State), 32'd2);
    check("fetch_mar", wMAROut, 32'd0);

    // ALU and flags
    step("sethi", 32'h04);
    check("sethi_r1", dut.regs[1], 32'h7FFFFC00);
    step("or", 32'h08);
    check("or_r1", dut.regs[1], 32'h7FFFFFFF);
    step("addcc", 32'h0C);
    check("addcc_r2", dut.regs[2], 32'h80000000);
    check("addcc_fr", 32'(dut.fr_reg), 32'b0110);
    step("subcc", 32'h10);
    check("subcc_r3", dut.regs[3], 32'h0);
    check("subcc_fr", 32'(dut.fr_reg), 32'b0001);

    // Call / jmpl / branches
    step("call", 32'h20);
    check("call_r15", dut.regs[15], 32'h10);
    step("jmpl", 32'h18);
    step("bn", 32'h1C);
    step("ba", 32'h30);
    step("be", 32'h38);
    step("bne", 32'h3C);
    step("ba2", 32'h4C);

    // Load / store
    access_mar = 32'd0;
    step("st", 32'h50);
    check("st_mar", access_mar, 32'h40);
    check("st_mem", {dut.mem[9'h40], dut.mem[9'h41], dut.mem[9'h42], dut.mem[9'h43]}, 32'h80000000);
    access_mar = 32'd0;
    step("ld", 32'h54);
    check("ld_mar", access_mar, 32'h40);
    check("ld_r4", dut.regs[4], 32'h80000000);
    step("ldub", 32'h58);
    check("ldub_r5", dut.regs[5], 32'h00000080);

    // Shifts leave flags alone
    step("sra", 32'h5C);
    check("sra_r6", dut.regs[6], 32'hF8000000);
    check("sra_fr", 32'(dut.fr_reg), 32'b0001);
    step("srl", 32'h60);
    check("srl_r7", dut.regs[7], 32'h08000000);

    // Illegal opcode halts until reset
    begin
      bit halted = 1'b0;
      for (int c = 0; c < 20 && !halted; c++) begin
        @(posedge Clk);
        #1;
        if (State == 7'd63) halted = 1'b1;
      end
      check("halt_reached", {31'd0, halted}, 32'd1);
    end
    repeat (5) @(posedge Clk);
    #1;
    check("halt_hold", 32'(State), 32'd63);
    check("halt_ir", wIROut, ILLEGAL);
    $display("step halt   state=%0d ir=%h", State, wIROut);
    Clr = 1'b1;
    @(posedge Clk);
    #1;
    check("clr_state", 32'(State), 32'd0);
    check("clr_pc", dut.pc_reg, 32'd0);
    check("clr_ir", wIROut, 32'd0);
    check("clr_r2_kept", dut.regs[2], 32'h80000000);
    Clr = 1'b0;
    @(posedge Clk);
    #1;
    check("clr_fetch", 32'(State), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
